display_scanner: RTL

- Downstream consumer of the multi-device display bus (`displays_flattened`): one 8-bit field per device, {dot, 7 segments}, already in pin polarity.
- Time-multiplexes DEVICE_NUM fields onto one shared segment bus plus per-digit anode selects, for a board with a single common-anode 7-segment bank.
- Inserts a blanking gap at each digit switch to prevent ghosting.
- Snapshots the whole bus once per frame so a refresh never shows a half-updated frame (no tearing).

---
 rtl/display_scanner_if.sv | 25 ++
 rtl/display_scanner.sv | 98 +++++++++
 2 files changed

// File: rtl/display_scanner_if.sv
// Bundle between a display scanner and its driver: scan enable, the
// multi-device field bus, and the multiplexed segment/anode/frame outputs.
interface display_scanner_if #(
  parameter int DEVICE_WIDTH   = 2,
  parameter int ENCODING_WIDTH = 7
);
  localparam int DEVICE_NUM = 2 ** DEVICE_WIDTH;
  localparam int FIELD_W    = ENCODING_WIDTH + 1;

  logic                            enable;
  logic [FIELD_W*DEVICE_NUM-1:0]   displays_flattened;
  logic [FIELD_W-1:0]              segments;
  logic [DEVICE_NUM-1:0]           anodes;
  logic                            frame_start;

  modport master (
    output enable, displays_flattened,
    input  segments, anodes, frame_start
  );

  modport slave (
    input  enable, displays_flattened,
    output segments, anodes, frame_start
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexes DEVICE_NUM {dot, segment} fields onto one common-anode bank,
// with a per-slot blanking gap and a once-per-frame snapshot of the input bus.
module display_scanner #(
  parameter int DEVICE_WIDTH   = 2,
  parameter int ENCODING_WIDTH = 7,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  display_scanner_if.slave   bus
);
  localparam int DEVICE_NUM = 2 ** DEVICE_WIDTH;
  localparam int FIELD_W    = ENCODING_WIDTH + 1;
  localparam int BUS_W      = FIELD_W * DEVICE_NUM;
  localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [DEVICE_WIDTH-1:0] DIGIT_LAST = {DEVICE_WIDTH{1'b1}};
  localparam logic [DEVICE_NUM-1:0]   AN_OFF     = {DEVICE_NUM{AN_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEVICE_WIDTH-1:0] digit_q, digit_d;
  logic [BUS_W-1:0]        snap_q, snap_d;
  logic                    run_q, run_d;
  logic [FIELD_W-1:0]      seg_q, seg_d;
  logic [DEVICE_NUM-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;
  logic                    frame_go;

  function automatic logic [DEVICE_NUM-1:0] anode_sel(input logic [DEVICE_WIDTH-1:0] d);
    logic [DEVICE_NUM-1:0] onehot;
    onehot    = '0;
    onehot[d] = 1'b1;
    return (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
  endfunction

  always_comb begin
    frame_go = bus.enable && (!run_q || (cnt_q == CNT_LAST && digit_q == DIGIT_LAST));
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    snap_d   = snap_q;
    run_d    = run_q;
    seg_d    = '1;
    an_d     = AN_OFF;
    fs_d     = 1'b0;

    if (!bus.enable) begin
      cnt_d   = '0;
      digit_d = '0;
      run_d   = 1'b0;
    end else begin
      if (frame_go) begin
        snap_d  = bus.displays_flattened;
        run_d   = 1'b1;
        cnt_d   = '0;
        digit_d = '0;
        fs_d    = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        digit_d = digit_q + 1'b1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end

      // Outputs are decoded from next state so they line up with the slot counter.
      if (int'(cnt_d) >= BLANK_CYCLES) begin
        seg_d = snap_d[digit_d*FIELD_W +: FIELD_W];
        an_d  = anode_sel(digit_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
      snap_q  <= '1;
      run_q   <= 1'b0;
      seg_q   <= '1;
      an_q    <= AN_OFF;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      run_q   <= run_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.segments    = seg_q;
  assign bus.anodes      = an_q;
  assign bus.frame_start = fs_q;
endmodule
